// File: rtl/tone_gen_pkg.sv
// Shared definitions for the tone generator's audio output path.
package tone_gen_pkg;
    localparam int SAMPLE_WIDTH = 16;
    localparam int FRAME_SLOTS  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/sample_serializer_if.sv
// Sample input and DAC pin bundle for the serial audio transmitter.
interface sample_serializer_if;
    import tone_gen_pkg::*;

    logic [SAMPLE_WIDTH-1:0] data_in;
    logic                    data_valid_in;
    logic                    flag_clear_in;
    logic                    bclk_out;
    logic                    lrck_out;
    logic                    sdata_out;
    logic                    busy_out;
    logic                    overrun_out;
    logic                    underrun_out;

    modport master (
        output data_in, data_valid_in, flag_clear_in,
        input  bclk_out, lrck_out, sdata_out, busy_out, overrun_out, underrun_out
    );

    modport slave (
        input  data_in, data_valid_in, flag_clear_in,
        output bclk_out, lrck_out, sdata_out, busy_out, overrun_out, underrun_out
    );
endinterface

// File: rtl/bclk_divider.sv
// Bit-clock generator: free-runs while enabled, toggles bclk every CLK_DIV cycles.
module bclk_divider #(
    parameter int CLK_DIV = 8
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic en,
    output logic bclk,
    output logic rise_stb,
    output logic fall_stb
);
    localparam logic [7:0] TC = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;
    logic       tc_hit;

    assign tc_hit   = en && (div_cnt == TC);
    // Strobes mark the cycle whose closing edge moves bclk, so the consumer updates in lockstep.
    assign rise_stb = tc_hit && !bclk;
    assign fall_stb = tc_hit && bclk;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc_hit) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/sample_serializer.sv
// Left-justified stereo serializer: one held sample, repeated in both slots of each frame.
//   state | meaning
//   IDLE  | no sample yet; all pins low, waiting for the holding buffer to fill
//   RUN   | streaming frames forever; left only through reset
module sample_serializer
    import tone_gen_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic                clk_in,
    input  logic                reset_n_in,
    sample_serializer_if.slave  bus
);
    localparam int SLOT_W = $clog2(FRAME_SLOTS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);

    state_t                  state;
    logic [SAMPLE_WIDTH-1:0] hold_buf;
    logic [SAMPLE_WIDTH-1:0] frame_buf;
    logic [SAMPLE_WIDTH-1:0] next_frame;
    logic                    hold_full;
    logic [SLOT_W-1:0]       slot_cnt;
    logic [SLOT_W-1:0]       slot_next;
    logic                    bclk;
    logic                    rise_stb;
    logic                    fall_stb;
    logic                    boundary;
    logic                    load;
    logic                    lrck;
    logic                    sdata;
    logic                    busy;
    logic                    overrun;
    logic                    underrun;

    bclk_divider #(.CLK_DIV(CLK_DIV)) u_bclk_divider (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .en         (state == RUN),
        .bclk       (bclk),
        .rise_stb   (rise_stb),
        .fall_stb   (fall_stb)
    );

    assign boundary   = fall_stb && (slot_cnt == LAST_SLOT);
    assign load       = hold_full && ((state == IDLE) || boundary);
    assign next_frame = load ? hold_buf : frame_buf;
    assign slot_next  = slot_cnt + 1'b1;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state     <= IDLE;
            hold_buf  <= '0;
            hold_full <= 1'b0;
            frame_buf <= '0;
            slot_cnt  <= '0;
            lrck      <= 1'b0;
            sdata     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            // A strobe coinciding with a load refills the buffer, so hold_full stays set.
            if (bus.data_valid_in) begin
                hold_buf  <= bus.data_in;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (load) frame_buf <= hold_buf;

            if (bus.data_valid_in && hold_full && !load) overrun <= 1'b1;
            else if (bus.flag_clear_in)                  overrun <= 1'b0;

            if (boundary && !hold_full)  underrun <= 1'b1;
            else if (bus.flag_clear_in)  underrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (hold_full) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        slot_cnt <= '0;
                        lrck     <= 1'b0;
                        sdata    <= next_frame[SAMPLE_WIDTH-1];
                    end
                end
                RUN: begin
                    if (fall_stb) begin
                        slot_cnt <= slot_next;
                        lrck     <= slot_next[SLOT_W-1];
                        sdata    <= next_frame[4'(SAMPLE_WIDTH - 1) - slot_next[3:0]];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk_in) disable iff (!reset_n_in) !(rise_stb && fall_stb));

    assign bus.bclk_out     = bclk;
    assign bus.lrck_out     = lrck;
    assign bus.sdata_out    = sdata;
    assign bus.busy_out     = busy;
    assign bus.overrun_out  = overrun;
    assign bus.underrun_out = underrun;
endmodule

// File: tb/tb_sample_serializer.sv
// Scoreboard bench for sample_serializer at CLK_DIV=2 (128-cycle frames).
module tb_sample_serializer;
    typedef struct {
        int          idx;
        logic [15:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    sample_serializer_if bus ();

    sample_serializer #(.CLK_DIV(2)) dut (
        .clk_in     (clk),
        .reset_n_in (rst_n),
        .bus        (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: assemble 32 bits per frame on rising bclk, compare against indexed expectations.
    int          bit_cnt = 0;
    int          frame_idx = 0;
    int          lr_err = 0;
    logic        prev_bclk = 1'b0;
    logic [31:0] shreg = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            bit_cnt   = 0;
            frame_idx = 0;
            lr_err    = 0;
            prev_bclk = 1'b0;
        end else begin
            if (bus.bclk_out && !prev_bclk) begin
                if (bus.lrck_out !== (bit_cnt >= 16)) lr_err++;
                shreg = {shreg[30:0], bus.sdata_out};
                bit_cnt++;
                if (bit_cnt == 32) begin
                    while (sb.size() > 0 && sb[0].idx < frame_idx) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL frame_missed: got no frame for idx %0d required %h", sb[0].idx, sb[0].val);
                        void'(sb.pop_front());
                    end
                    if (sb.size() > 0 && sb[0].idx == frame_idx) begin
                        exp_t e;
                        e = sb.pop_front();
                        n_cmp++;
                        if (shreg !== {e.val, e.val} || lr_err != 0) begin
                            n_err++;
                            $display("FAIL frame%0d: got %h (lrck errs %0d) required %h%h", frame_idx, shreg, lr_err, e.val, e.val);
                        end
                    end
                    frame_idx++;
                    bit_cnt = 0;
                    lr_err  = 0;
                end
            end
            prev_bclk = bus.bclk_out;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.bclk_out, bus.lrck_out, bus.sdata_out, bus.busy_out, bus.overrun_out, bus.underrun_out};
    endfunction

    task automatic strobe(input logic [15:0] d);
        bus.data_in       = d;
        bus.data_valid_in = 1'b1;
        tick(1);
        bus.data_valid_in = 1'b0;
    endtask

    task automatic expect_frame(input int idx, input logic [15:0] v);
        exp_t e;
        e.idx = idx;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while (sb.size() != 0 && c < budget) begin
            tick(1);
            c++;
        end
        check(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic do_reset(input string name);
        bus.data_in       = '0;
        bus.data_valid_in = 1'b0;
        bus.flag_clear_in = 1'b0;
        rst_n = 1'b0;
        tick(2);
        check(name, 32'(outs()), 32'd0);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        int bad;
        rst_n             = 1'b1;
        bus.data_in       = '0;
        bus.data_valid_in = 1'b0;
        bus.flag_clear_in = 1'b0;
        #2;

        // Reset, no strobe: everything quiet
        do_reset("reset_outs");
        bad = 0;
        repeat (1000) begin
            tick(1);
            if (outs() !== 6'd0) bad++;
        end
        check("idle_quiet_cycles_bad", 32'(bad), 32'd0);

        // Single strobe A5C3: latency and first bit-clock rise
        do_reset("reset_a5c3");
        strobe(16'hA5C3);
        check("busy_at_t1", 32'(bus.busy_out), 32'd0);
        tick(1);
        check("busy_at_t2", 32'(bus.busy_out), 32'd1);
        check("msb_at_t2", 32'(bus.sdata_out), 32'd1);
        check("lrck_at_t2", 32'(bus.lrck_out), 32'd0);
        check("bclk_at_t2", 32'(bus.bclk_out), 32'd0);
        tick(1);
        check("bclk_at_t3", 32'(bus.bclk_out), 32'd0);
        tick(1);
        check("bclk_at_t4", 32'(bus.bclk_out), 32'd1);
        expect_frame(0, 16'hA5C3);
        drain("drain_a5c3", 400);

        // Mid-frame strobes feed consecutive frames without flags
        do_reset("reset_seq");
        expect_frame(0, 16'h0F0F);
        expect_frame(1, 16'h1234);
        expect_frame(2, 16'h8001);
        strobe(16'h0F0F);
        tick(1);
        tick(63);
        strobe(16'h1234);
        tick(127);
        strobe(16'h8001);
        tick(100);
        check("seq_overrun", 32'(bus.overrun_out), 32'd0);
        check("seq_underrun", 32'(bus.underrun_out), 32'd0);
        drain("drain_seq", 600);

        // Two strobes within one frame: overrun, newest wins
        do_reset("reset_ovr");
        expect_frame(0, 16'h0F0F);
        expect_frame(1, 16'h2222);
        strobe(16'h0F0F);
        tick(1);
        tick(19);
        strobe(16'h1111);
        check("ovr_after_first", 32'(bus.overrun_out), 32'd0);
        tick(19);
        strobe(16'h2222);
        check("ovr_after_second", 32'(bus.overrun_out), 32'd1);
        drain("drain_ovr", 600);

        // Starved: frame repeats, underrun sets on wrap, clear holds until next wrap
        do_reset("reset_und");
        expect_frame(0, 16'h7FFF);
        expect_frame(1, 16'h7FFF);
        strobe(16'h7FFF);
        tick(1);
        tick(127);
        check("und_before_wrap", 32'(bus.underrun_out), 32'd0);
        tick(1);
        check("und_at_wrap", 32'(bus.underrun_out), 32'd1);
        bus.flag_clear_in = 1'b1;
        tick(1);
        bus.flag_clear_in = 1'b0;
        check("und_cleared", 32'(bus.underrun_out), 32'd0);
        tick(126);
        check("und_before_wrap2", 32'(bus.underrun_out), 32'd0);
        tick(1);
        check("und_at_wrap2", 32'(bus.underrun_out), 32'd1);
        drain("drain_und", 300);

        // Async reset in slot 20, then restart from IDLE
        do_reset("reset_abort");
        strobe(16'hBEEF);
        tick(1);
        tick(81);
        check("abort_running", 32'(bus.busy_out), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_async_outs", 32'(outs()), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("abort_idle_outs", 32'(outs()), 32'd0);
        strobe(16'hC001);
        check("restart_busy_t1", 32'(bus.busy_out), 32'd0);
        tick(1);
        check("restart_busy_t2", 32'(bus.busy_out), 32'd1);
        check("restart_msb_t2", 32'(bus.sdata_out), 32'd1);
        expect_frame(0, 16'hC001);
        drain("drain_restart", 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
